unit_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one 1-bit combinational unit
//  (single `in`, single `out`) between NREQ clients.
//  - Grants one requester and drives that client's bit onto the unit input.
//  - Holds the input for HOLD settle cycles, then samples the unit output.
//  - Returns the result with a one-cycle response strobe tagged by client id.

---
 rtl/unit_share_arbiter_pkg.sv | 15 +
 rtl/unit_share_arbiter_if.sv | 28 ++
 rtl/unit_share_arbiter_rr_pick.sv | 29 ++
 rtl/unit_share_arbiter.sv | 98 +++++++++
 tb/tb_unit_share_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/unit_share_arbiter_pkg.sv
// Shared types for the unit-share arbiter: FSM state encoding
// (ST_IDLE=1'b0, ST_DRIVE=1'b1) and a wrap-increment helper.
package unit_share_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   // id+1 modulo n, without a divider
   function automatic int wrap_next(int id, int n);
      return (id + 1 == n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/unit_share_arbiter_if.sv
// Client-side bundle of the shared 1-bit unit arbiter.
// master: client/unit side, slave: the arbiter itself.
interface unit_share_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_bit;
   logic [NREQ-1:0] gnt;
   logic            busy;
   logic            unit_in;
   logic            unit_out;
   logic            rsp_valid;
   logic [IDW-1:0]  rsp_id;
   logic            rsp_bit;

   modport master (
      output req, req_bit, unit_out,
      input  gnt, busy, unit_in,
      input  rsp_valid, rsp_id, rsp_bit
   );

   modport slave (
      input  req, req_bit, unit_out,
      output gnt, busy, unit_in,
      output rsp_valid, rsp_id, rsp_bit
   );
endinterface

// File: rtl/unit_share_arbiter_rr_pick.sv
// Rotate-priority picker: first set req[i] scanning from ptr upward
// with wrap.  Ports: req, ptr in; any (some req set), idx out.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            any,
   output logic [IDW-1:0]  idx
);

   logic [IDW-1:0] j;

   // Scan from the farthest offset down so the nearest hit wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      j   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = IDW'((int'(ptr) + k) % NREQ);
         if (req[j]) begin
            any = 1'b1;
            idx = j;
         end
      end
   end

endmodule

// File: rtl/unit_share_arbiter.sv
// Round-robin sequencer sharing one 1-bit unit among NREQ clients.
// Ports: clk, reset (sync, high), bus (slave modport of the bundle).
module unit_share_arbiter
   import unit_share_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int HOLD = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               reset,
   unit_share_arbiter_if.slave bus
);

   localparam int CW = $clog2(HOLD + 1);

   state_e          state_q;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  ptr_d;
   logic [IDW-1:0]  id_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;
   logic            unit_in_q;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic            rsp_bit_q;

   logic            pick_any;
   logic [IDW-1:0]  pick_idx;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign ptr_d = IDW'(wrap_next(int'(id_q), NREQ));
   assign cnt_d = cnt_q - 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         unit_in_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_bit_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt_q     <= NREQ'(1) << pick_idx;
                  unit_in_q <= bus.req_bit[pick_idx];
                  id_q      <= pick_idx;
                  cnt_q     <= CW'(HOLD);
                  busy_q    <= 1'b1;
                  state_q   <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               // Last settle cycle: unit_out has seen unit_in for HOLD cycles.
               if (cnt_q == CW'(1)) begin
                  rsp_bit_q   <= bus.unit_out;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  ptr_q       <= ptr_d;
                  gnt_q       <= '0;
                  busy_q      <= 1'b0;
                  unit_in_q   <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.busy      = busy_q;
   assign bus.unit_in   = unit_in_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_bit   = rsp_bit_q;

endmodule

// File: tb/tb_unit_share_arbiter.sv
// Bench for unit_share_arbiter: directed scenarios plus random traffic
// against a transaction-window reference model (unit = inverter).
module tb_unit_share_arbiter;
   import unit_share_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int HOLD = 2;
   localparam int IDW  = 2;

   logic clk;
   logic reset;

   unit_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   assign bus.unit_out = ~bus.unit_in;

   unit_share_arbiter #(
      .NREQ (NREQ),
      .HOLD (HOLD),
      .IDW  (IDW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: one transaction window [t0, t0+HOLD]
   int  e = 0;
   bit  act = 0;
   int  t0 = 0;
   int  mid = 0;
   bit  mdrv = 0;
   int  mptr = 0;
   bit  mrv = 0;
   int  mrid = 0;
   bit  mrbit = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [NREQ-1:0] r, int p);
      for (int off = 0; off < NREQ; off++) begin
         if (r[(p + off) % NREQ]) return (p + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_edge();
      logic [NREQ-1:0] rq;
      logic [NREQ-1:0] rb;
      rq  = bus.req;
      rb  = bus.req_bit;
      mrv = 0;
      if (reset) begin
         act   = 0;
         mptr  = 0;
         mrid  = 0;
         mrbit = 0;
      end else if (act) begin
         if (e == t0 + HOLD) begin
            act   = 0;
            mrv   = 1;
            mrid  = mid;
            mrbit = ~mdrv;
            mptr  = (mid + 1) % NREQ;
         end
      end else if (rq != '0) begin
         mid  = pick(rq, mptr);
         act  = 1;
         t0   = e;
         mdrv = rb[mid];
      end
      e++;
   endtask

   task automatic check_all();
      chk("gnt", 32'(bus.gnt), act ? (32'd1 << mid) : 32'd0);
      chk("busy", 32'(bus.busy), 32'(act));
      chk("unit_in", 32'(bus.unit_in), 32'(act & mdrv));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(mrv));
      chk("rsp_id", 32'(bus.rsp_id), 32'(mrid));
      chk("rsp_bit", 32'(bus.rsp_bit), 32'(mrbit));
      chk("state", 32'(dut.state_q), act ? 32'(ST_DRIVE) : 32'(ST_IDLE));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   int got_id[$];
   int got_bit[$];
   int got_at[$];
   int exp_id[5]  = '{0, 1, 2, 3, 0};
   int exp_bit[5] = '{1, 0, 1, 0, 1};
   int exp_at[5]  = '{2, 5, 8, 11, 14};

   initial begin
      reset       = 1'b1;
      bus.req     = '0;
      bus.req_bit = '0;

      // 1: reset held with all requests up
      bus.req = 4'b1111;
      step();
      step();
      chk("rst_gnt", 32'(bus.gnt), 32'd0);

      // 2: single client 2
      reset       = 1'b0;
      bus.req     = 4'b0100;
      bus.req_bit = 4'b0100;
      step();
      chk("t2_gnt", 32'(bus.gnt), 32'h4);
      chk("t2_uin", 32'(bus.unit_in), 32'd1);
      bus.req = '0;
      step();
      chk("t2_gnt2", 32'(bus.gnt), 32'h4);
      step();
      chk("t2_rv", 32'(bus.rsp_valid), 32'd1);
      chk("t2_id", 32'(bus.rsp_id), 32'd2);
      chk("t2_bit", 32'(bus.rsp_bit), 32'd0);

      // 3: all request from ptr=0, five back-to-back transactions
      reset = 1'b1;
      step();
      reset       = 1'b0;
      bus.req     = 4'b1111;
      bus.req_bit = 4'b1010;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.rsp_valid) begin
            got_id.push_back(int'(bus.rsp_id));
            got_bit.push_back(int'(bus.rsp_bit));
            got_at.push_back(i);
         end
      end
      bus.req = '0;
      chk("t3_cnt", 32'(got_id.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got_id.size()) begin
            chk("t3_id", 32'(got_id[i]), 32'(exp_id[i]));
            chk("t3_bit", 32'(got_bit[i]), 32'(exp_bit[i]));
            chk("t3_at", 32'(got_at[i]), 32'(exp_at[i]));
         end
      end

      // 4: id 3 completes, then wrap with client 0 skipped
      reset = 1'b1;
      step();
      reset   = 1'b0;
      bus.req = 4'b1000;
      step();
      bus.req = '0;
      step();
      step();
      chk("t4_id3", 32'(bus.rsp_id), 32'd3);
      bus.req = 4'b0110;
      step();
      chk("t4_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      step();
      step();
      chk("t4_rv", 32'(bus.rsp_valid), 32'd1);
      chk("t4_id", 32'(bus.rsp_id), 32'd1);

      // 5: reset in first grant cycle aborts
      bus.req = 4'b1111;
      step();
      reset   = 1'b1;
      bus.req = '0;
      step();
      chk("t5_gnt0", 32'(bus.gnt), 32'd0);
      chk("t5_uin0", 32'(bus.unit_in), 32'd0);
      chk("t5_rv0", 32'(bus.rsp_valid), 32'd0);
      reset   = 1'b0;
      bus.req = 4'b1111;
      step();
      chk("t5_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      step();
      step();

      // 6: request dropped during grant still completes
      bus.req     = 4'b0001;
      bus.req_bit = 4'b0000;
      step();
      bus.req = '0;
      step();
      chk("t6_gnt", 32'(bus.gnt), 32'h1);
      step();
      chk("t6_rv", 32'(bus.rsp_valid), 32'd1);
      chk("t6_id", 32'(bus.rsp_id), 32'd0);
      chk("t6_bit", 32'(bus.rsp_bit), 32'd1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 39) == 0);
         bus.req     = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
         bus.req_bit = 4'($urandom);
         step();
      end
      reset   = 1'b0;
      bus.req = '0;
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
